// File: rtl/seq_detect_moore_param_if.sv
// Serial detector bus: qualified bit stream, pattern reload and counter control
// in, match flag/state/count out.
interface seq_detect_moore_param_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8,
  parameter int SW    = $clog2(N+1)
);
  logic             din;
  logic             din_valid;
  logic             ovl;
  logic             pat_load;
  logic [N-1:0]     pat_in;
  logic             clr_count;
  logic             y;
  logic [SW-1:0]    state_out;
  logic [CNT_W-1:0] match_count;

  modport master (
    output din, din_valid, ovl, pat_load, pat_in, clr_count,
    input  y, state_out, match_count
  );

  modport slave (
    input  din, din_valid, ovl, pat_load, pat_in, clr_count,
    output y, state_out, match_count
  );
endinterface

// File: rtl/seq_detect_moore_param.sv
// Moore serial pattern detector with runtime-loadable pattern, overlap select
// and a saturating match counter. Next state follows the KMP failure rule.
module seq_detect_moore_param #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1010,
  parameter int             CNT_W   = 8,
  localparam int            SW      = $clog2(N+1)
) (
  input  logic                      clk,
  input  logic                      reset,
  seq_detect_moore_param_if.slave   bus
);

  localparam logic [SW-1:0] N_S = SW'(N);

  logic [SW-1:0]    state_q, state_d;
  logic [N-1:0]     pat_q, pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [SW-1:0]    k;
  logic [SW-1:0]    nxt;
  logic [N:0]       cand;
  logic [N:0]       mask;

  always_comb begin
    pat_d   = pat_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    mask    = '0;
    nxt     = '0;

    // Non-overlap mode restarts from an empty prefix after a full match.
    k = (state_q == N_S && !bus.ovl) ? '0 : state_q;

    // Matched prefix (oldest bit at MSB) followed by the incoming bit in bit 0.
    cand = {pat_q >> (N_S - k), bus.din};

    // Longest suffix of cand that is also a pattern prefix; later (longer) wins.
    for (int l = 1; l <= N; l++) begin
      mask = ~({(N+1){1'b1}} << l);
      if (l <= int'(k) + 1 &&
          ((cand ^ {1'b0, pat_q >> (N - l)}) & mask) == '0)
        nxt = SW'(l);
    end

    if (bus.pat_load) begin
      pat_d   = bus.pat_in;
      state_d = '0;
    end else if (bus.din_valid) begin
      state_d = nxt;
      if (nxt == N_S && cnt_q != {CNT_W{1'b1}})
        cnt_d = cnt_q + CNT_W'(1);
    end

    if (bus.clr_count)
      cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= '0;
      pat_q   <= PATTERN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.y           = (state_q == N_S);
  assign bus.state_out   = state_q;
  assign bus.match_count = cnt_q;

endmodule

// File: doc/seq_detect_moore_param.md
Name: seq_detect_moore_param

Overview:
Parametrised Moore-type serial pattern detector, the successor to the fixed 4-bit 1010 overlap detector. Pattern length is a parameter. The pattern value can be reloaded at runtime, and overlap or non-overlap mode is selectable per cycle. The block adds an input qualifier and a saturating match counter. It sits on a serial bitstream path as a framing/sync-word detector.

Parameters:
N, 4, pattern length in bits (N >= 2)
PATTERN, 4'b1010, reset/default pattern; bit N-1 is the first bit received
CNT_W, 8, width of the match counter
SW, $clog2(N+1), state width (derived, not overridden)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous active-high reset
din  input  1  serial data bit
din_valid  input  1  din is sampled only when 1
ovl  input  1  1 = overlapping detection, 0 = non-overlapping
pat_load  input  1  load pat_in into pattern register
pat_in  input  N  new pattern, MSB first
clr_count  input  1  clear match counter
y  output  1  Moore match flag
state_out  output  SW  current state (number of pattern bits matched, 0..N)
match_count  output  CNT_W  saturating count of matches

Behaviour:
- Reset: clk is the single clock; reset is synchronous and active-high. On a clk edge with reset=1: state=0, y=0, match_count=0, pattern register=PATTERN. reset overrides all other inputs.
- State meaning: state k (0..N) means the last k sampled bits equal the first k pattern bits, pat[N-1 -: k].
- y is a pure function of the registered state: y = (state == N). No combinational path from din to y.
- Latency: y rises in the cycle after the edge that samples the final pattern bit.
- Valid sample (din_valid=1, no pat_load):
  - Let s' = {first state bits consumed, din}.
  - next state = longest L <= N such that the last L bits of (matched prefix followed by din) equal pat[N-1 -: L]. This is the KMP failure-function rule, computed combinationally from the pattern register, so a runtime pattern needs no precomputed table.
- State N with ovl=1: the next state uses the full N-bit matched prefix, so overlap is retained. Example, 1010: 1010 then 1 -> state 3; then 0 -> state 4 (match).
- State N with ovl=0: the next state is computed as if from state 0 with din, so the matched bits are discarded.
- din_valid=0: state, y and counter hold.
- pat_load=1 (reset=0): pattern register <= pat_in, state <= 0, and din is ignored that cycle. match_count is unchanged unless clr_count=1.
- Counter:
  - Increments by 1 on every valid sample whose next state is N. This includes consecutive matches, e.g. pattern 1111 with ovl=1 on an all-ones stream: y stays high and the count increments every valid cycle.
  - Saturates at 2^CNT_W-1.
  - clr_count=1 forces 0 and takes priority over an increment in the same cycle.
- Priority: reset > pat_load > din_valid sample. clr_count is independent of pat_load.
- ovl is sampled only on the transition out of state N; it may change at any time.
- Reset mid-pattern: partial match is discarded; the next sample starts from state 0.

Test Plan:
- Overlap, N=4, PATTERN=1010, ovl=1, din_valid=1, stream 1,1,1,0,1,0,1,0,1 (one bit/cycle after reset) -> y high one cycle after the 6th and the 8th sampled bits; match_count=2; state_out sequence 1,1,1,2,3,4,3,4,3.
- Non-overlap: same stream, ovl=0 -> y high only after the 6th bit; match_count=1; state after the 7th bit = 1.
- Gapped input: 1010 delivered with din_valid=0 for 3 cycles between each bit, din toggling randomly during the gaps -> single y pulse after the 4th valid bit; state frozen during the gaps.
- Runtime reload: pat_load with pat_in=0110 while in state 3 -> state 0 next cycle; stream 0,1,1,0,1,1,0 with ovl=1 -> matches after bits 4 and 7; count=2, counter not cleared by the load.
- Saturation/clear: CNT_W=2, pattern 1111, ovl=1, 8 ones -> count 1,2,3,3,3 and y held high from the 4th bit on. Assert clr_count on a matching cycle -> count=0 that cycle, 1 on the next match.
- Reset mid-operation: reach state 3 of 1010, assert reset for one cycle with din=0 -> state 0, y 0, count 0; the following 0 does not produce a match.
